// File: rtl/alu_accum_seq.sv
// WIDTH-bit accumulator ALU with a valid/ready operand handshake, a shift-add
// multiplier, wrap/saturate overflow handling and an OFF/READY/RUN/ERROR FSM.
module alu_accum_seq #(
    parameter int WIDTH = 8,
    parameter bit SAT   = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             on,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic             use_acc,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             out_valid,
    output logic             ovf,
    output logic             err,
    output logic [1:0]       state
);
    localparam logic [1:0] ST_OFF   = 2'b00;
    localparam logic [1:0] ST_READY = 2'b01;
    localparam logic [1:0] ST_RUN   = 2'b10;
    localparam logic [1:0] ST_ERROR = 2'b11;

    localparam logic [2:0] OP_AND = 3'd0;
    localparam logic [2:0] OP_OR  = 3'd1;
    localparam logic [2:0] OP_XOR = 3'd2;
    localparam logic [2:0] OP_NOT = 3'd3;
    localparam logic [2:0] OP_ADD = 3'd4;
    localparam logic [2:0] OP_SUB = 3'd5;
    localparam logic [2:0] OP_MUL = 3'd6;
    localparam logic [2:0] OP_CLR = 3'd7;

    localparam int                CW        = $clog2(WIDTH);
    localparam logic [CW-1:0]     LAST_STEP = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0]  ALL_ONES  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0]  ALL_ZERO  = {WIDTH{1'b0}};

    logic [1:0]         state_r;
    logic [1:0]         state_nxt_s;
    logic [WIDTH-1:0]   acc_r;
    logic               out_valid_r;
    logic               ovf_r;
    logic               err_r;
    logic [2*WIDTH-1:0] mcand_r;
    logic [WIDTH-1:0]   mplier_r;
    logic [2*WIDTH-1:0] prod_r;
    logic [CW-1:0]      step_r;

    logic               accept_s;
    logic [WIDTH-1:0]   opa_s;
    logic [WIDTH:0]     sum_s;
    logic [WIDTH-1:0]   alu_res_s;
    logic               alu_ovf_s;
    logic [2*WIDTH-1:0] prod_next_s;
    logic               mul_final_s;
    logic               mul_ovf_s;
    logic [WIDTH-1:0]   mul_res_s;

    assign in_ready  = (state_r == ST_READY);
    assign accept_s  = in_valid && (state_r == ST_READY);
    assign opa_s     = use_acc ? acc_r : a;
    assign result    = acc_r;
    assign out_valid = out_valid_r;
    assign ovf       = ovf_r;
    assign err       = err_r;
    assign state     = state_r;

    // Single-cycle ALU result and overflow for the op being offered
    always_comb begin
        sum_s     = {1'b0, opa_s} + {1'b0, b};
        alu_res_s = ALL_ZERO;
        alu_ovf_s = 1'b0;
        case (op)
            OP_AND: alu_res_s = opa_s & b;
            OP_OR:  alu_res_s = opa_s | b;
            OP_XOR: alu_res_s = opa_s ^ b;
            OP_NOT: alu_res_s = ~opa_s;
            OP_ADD: begin
                alu_ovf_s = sum_s[WIDTH];
                alu_res_s = (SAT && sum_s[WIDTH]) ? ALL_ONES : sum_s[WIDTH-1:0];
            end
            OP_SUB: begin
                alu_ovf_s = (opa_s < b);
                alu_res_s = (SAT && (opa_s < b)) ? ALL_ZERO : (opa_s - b);
            end
            OP_MUL:  alu_res_s = ALL_ZERO;
            OP_CLR:  alu_res_s = ALL_ZERO;
            default: alu_res_s = ALL_ZERO;
        endcase
    end

    // Shift-add step; the final step's sum is the complete 2*WIDTH product
    always_comb begin
        prod_next_s = prod_r + (mplier_r[0] ? mcand_r : {(2*WIDTH){1'b0}});
        mul_final_s = (state_r == ST_RUN) && (step_r == LAST_STEP);
        mul_ovf_s   = |prod_next_s[2*WIDTH-1:WIDTH];
        mul_res_s   = (SAT && mul_ovf_s) ? ALL_ONES : prod_next_s[WIDTH-1:0];
    end

    // Next-state decode
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_OFF: begin
                if (on) state_nxt_s = ST_READY;
                else    state_nxt_s = ST_OFF;
            end
            ST_READY: begin
                if (accept_s && (op == OP_MUL))  state_nxt_s = ST_RUN;
                else if (accept_s && alu_ovf_s)  state_nxt_s = ST_ERROR;
                else if (!on)                    state_nxt_s = ST_OFF;
                else                             state_nxt_s = ST_READY;
            end
            ST_RUN: begin
                if (!mul_final_s)   state_nxt_s = ST_RUN;
                else if (mul_ovf_s) state_nxt_s = ST_ERROR;
                else if (on)        state_nxt_s = ST_READY;
                else                state_nxt_s = ST_OFF;
            end
            ST_ERROR: begin
                if (on) state_nxt_s = ST_READY;
                else    state_nxt_s = ST_OFF;
            end
            default: state_nxt_s = ST_OFF;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_r <= ST_OFF;
        else      state_r <= state_nxt_s;
    end

    // Accumulator, result flags and multiplier datapath
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_r       <= ALL_ZERO;
            out_valid_r <= 1'b0;
            ovf_r       <= 1'b0;
            err_r       <= 1'b0;
            mcand_r     <= {(2*WIDTH){1'b0}};
            mplier_r    <= ALL_ZERO;
            prod_r      <= {(2*WIDTH){1'b0}};
            step_r      <= {CW{1'b0}};
        end else begin
            out_valid_r <= 1'b0;
            ovf_r       <= 1'b0;
            if (accept_s && (op == OP_MUL)) begin
                mcand_r  <= {ALL_ZERO, opa_s};
                mplier_r <= b;
                prod_r   <= {(2*WIDTH){1'b0}};
                step_r   <= {CW{1'b0}};
            end else if (accept_s) begin
                acc_r       <= alu_res_s;
                out_valid_r <= 1'b1;
                ovf_r       <= alu_ovf_s;
                if (op == OP_CLR)  err_r <= 1'b0;
                else if (alu_ovf_s) err_r <= 1'b1;
            end else if (state_r == ST_RUN) begin
                prod_r   <= prod_next_s;
                mcand_r  <= mcand_r << 1;
                mplier_r <= mplier_r >> 1;
                step_r   <= step_r + CW'(1);
                if (mul_final_s) begin
                    acc_r       <= mul_res_s;
                    out_valid_r <= 1'b1;
                    ovf_r       <= mul_ovf_s;
                    if (mul_ovf_s) err_r <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_alu_accum_seq.sv
// Bench for alu_accum_seq: wrap and saturate instances share one stimulus stream
// and are compared every cycle against a cycle-level arithmetic model.
module tb_alu_accum_seq;
    localparam int W     = 8;
    localparam int MAXV  = 255;
    localparam int S_OFF = 0;
    localparam int S_RDY = 1;
    localparam int S_RUN = 2;
    localparam int S_ERR = 3;

    logic         clk      = 1'b0;
    logic         rst      = 1'b0;
    logic         on       = 1'b0;
    logic         in_valid = 1'b0;
    logic         use_acc  = 1'b0;
    logic [2:0]   op       = 3'd0;
    logic [W-1:0] a        = 8'd0;
    logic [W-1:0] b        = 8'd0;

    logic         rdy [2];
    logic [W-1:0] res [2];
    logic         ovd [2];
    logic         ovf [2];
    logic         err [2];
    logic [1:0]   st  [2];

    int n_pass = 0;
    int n_chk  = 0;
    bit chk_en = 1'b0;
    int busy;

    // model state per instance; index 0 = wrap, 1 = saturate
    int m_state [2];
    int m_acc   [2];
    int m_err   [2];
    int m_ov    [2];
    int m_of    [2];
    int m_cnt   [2];
    int m_prod  [2];

    always #5 clk = ~clk;

    alu_accum_seq #(.WIDTH(W), .SAT(1'b0)) u_wrap (
        .clk(clk), .rst(rst), .on(on), .in_valid(in_valid), .in_ready(rdy[0]),
        .op(op), .use_acc(use_acc), .a(a), .b(b), .result(res[0]),
        .out_valid(ovd[0]), .ovf(ovf[0]), .err(err[0]), .state(st[0]));

    alu_accum_seq #(.WIDTH(W), .SAT(1'b1)) u_sat (
        .clk(clk), .rst(rst), .on(on), .in_valid(in_valid), .in_ready(rdy[1]),
        .op(op), .use_acc(use_acc), .a(a), .b(b), .result(res[1]),
        .out_valid(ovd[1]), .ovf(ovf[1]), .err(err[1]), .state(st[1]));

    task automatic check(input string name, input int k, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s[dut%0d] at %0t: got %0d, expected %0d", name, k, $time, act, exp);
    endtask

    task automatic model_step(input int k);
        int aa, bb, r, o, nxt;
        m_ov[k] = 0;
        m_of[k] = 0;
        nxt = on ? S_RDY : S_OFF;
        aa  = use_acc ? m_acc[k] : int'(a);
        bb  = int'(b);
        case (m_state[k])
            S_RDY: begin
                if (in_valid && op == 3'd6) begin
                    m_prod[k] = aa * bb;
                    m_cnt[k]  = W;
                    nxt       = S_RUN;
                end else if (in_valid) begin
                    o = 0;
                    case (op)
                        3'd0: r = aa & bb;
                        3'd1: r = aa | bb;
                        3'd2: r = aa ^ bb;
                        3'd3: r = MAXV - aa;
                        3'd4: begin
                            r = aa + bb;
                            o = (r > MAXV) ? 1 : 0;
                            if (o == 1) r = (k == 1) ? MAXV : r - (MAXV + 1);
                        end
                        3'd5: begin
                            o = (aa < bb) ? 1 : 0;
                            r = (o == 0) ? aa - bb : ((k == 1) ? 0 : aa - bb + MAXV + 1);
                        end
                        default: begin
                            r = 0;
                            m_err[k] = 0;
                        end
                    endcase
                    m_acc[k] = r;
                    m_ov[k]  = 1;
                    m_of[k]  = o;
                    if (o == 1) begin
                        m_err[k] = 1;
                        nxt      = S_ERR;
                    end
                end
            end
            S_RUN: begin
                m_cnt[k]--;
                if (m_cnt[k] == 0) begin
                    o        = (m_prod[k] > MAXV) ? 1 : 0;
                    m_acc[k] = (o == 1 && k == 1) ? MAXV : (m_prod[k] % (MAXV + 1));
                    m_ov[k]  = 1;
                    m_of[k]  = o;
                    if (o == 1) begin
                        m_err[k] = 1;
                        nxt      = S_ERR;
                    end
                end else begin
                    nxt = S_RUN;
                end
            end
            default: ;
        endcase
        m_state[k] = nxt;
    endtask

    always @(posedge clk or negedge rst) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst) begin
                m_state[k] = S_OFF; m_acc[k] = 0; m_err[k] = 0;
                m_ov[k] = 0; m_of[k] = 0; m_cnt[k] = 0; m_prod[k] = 0;
            end else begin
                model_step(k);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                check("result",    k, int'(res[k]), m_acc[k]);
                check("out_valid", k, int'(ovd[k]), m_ov[k]);
                check("ovf",       k, int'(ovf[k]), m_of[k]);
                check("err",       k, int'(err[k]), m_err[k]);
                check("state",     k, int'(st[k]),  m_state[k]);
                check("in_ready",  k, int'(rdy[k]), (m_state[k] == S_RDY) ? 1 : 0);
            end
        end
    end

    task automatic wait_ready();
        for (int i = 0; i < 40 && !rdy[0]; i++) @(negedge clk);
        if (!rdy[0]) check("ready_timeout", 0, int'(rdy[0]), 1);
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 40 && !ovd[0]; i++) @(negedge clk);
        if (!ovd[0]) check("valid_timeout", 0, int'(ovd[0]), 1);
    endtask

    task automatic do_op(input logic [2:0] o, input logic ua, input logic [W-1:0] aa,
                         input logic [W-1:0] bb);
        wait_ready();
        op = o; use_acc = ua; a = aa; b = bb; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        check("rst_state", 0, int'(st[0]), 0);
        rst = 1'b1;
        on  = 1'b1;

        // wrap ADD overflow, error state, then CLR
        do_op(3'd4, 1'b0, 8'd200, 8'd100);
        check("add_res", 0, int'(res[0]), 44);
        check("add_res", 1, int'(res[1]), 255);
        check("add_ovf", 0, int'(ovf[0]), 1);
        check("add_err", 0, int'(err[0]), 1);
        check("add_st",  0, int'(st[0]),  3);
        @(negedge clk);
        check("err_exit", 0, int'(st[0]), 1);
        do_op(3'd7, 1'b0, 8'd0, 8'd0);
        check("clr_res", 0, int'(res[0]), 0);
        check("clr_err", 1, int'(err[1]), 0);

        // multiply latency and overflow
        do_op(3'd6, 1'b0, 8'd15, 8'd17);
        busy = 0;
        for (int i = 0; i < 40 && !ovd[0]; i++) begin
            if (!rdy[0]) busy++;
            @(negedge clk);
        end
        check("mul_busy", 0, busy, 8);
        check("mul_res",  0, int'(res[0]), 255);
        check("mul_ovf",  0, int'(ovf[0]), 0);
        do_op(3'd6, 1'b1, 8'd0, 8'd2);
        wait_valid();
        check("mul2_res", 0, int'(res[0]), 254);
        check("mul2_res", 1, int'(res[1]), 255);
        check("mul2_ovf", 0, int'(ovf[0]), 1);
        check("mul2_st",  0, int'(st[0]),  3);
        @(negedge clk);
        check("mul2_exit", 0, int'(st[0]), 1);

        // async reset in the middle of a multiply
        do_op(3'd6, 1'b0, 8'd15, 8'd17);
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("arst_res", 0, int'(res[0]), 0);
        check("arst_err", 0, int'(err[0]), 0);
        check("arst_ov",  0, int'(ovd[0]), 0);
        check("arst_st",  0, int'(st[0]),  0);
        @(negedge clk);
        on = 1'b0; rst = 1'b1;
        op = 3'd4; a = 8'd1; b = 8'd1; in_valid = 1'b1;
        repeat (4) @(negedge clk);
        check("off_st",  0, int'(st[0]),  0);
        check("off_res", 0, int'(res[0]), 0);
        in_valid = 1'b0;

        // saturate mode
        on = 1'b1;
        do_op(3'd5, 1'b0, 8'd5, 8'd9);
        check("sub_res", 1, int'(res[1]), 0);
        check("sub_res", 0, int'(res[0]), 252);
        check("sub_ovf", 1, int'(ovf[1]), 1);
        do_op(3'd4, 1'b0, 8'd250, 8'd10);
        check("sadd_res", 1, int'(res[1]), 255);
        check("sadd_res", 0, int'(res[0]), 4);
        do_op(3'd6, 1'b0, 8'd16, 8'd16);
        wait_valid();
        check("smul_res", 1, int'(res[1]), 255);
        check("smul_res", 0, int'(res[0]), 0);
        check("smul_ovf", 1, int'(ovf[1]), 1);

        // back-to-back single-cycle ops
        wait_ready();
        op = 3'd2; use_acc = 1'b0; a = 8'hF0; b = 8'h3C; in_valid = 1'b1;
        @(negedge clk);
        op = 3'd3; use_acc = 1'b1;
        check("b2b_xor", 0, int'(res[0]), 8'hCC);
        @(negedge clk);
        op = 3'd0; b = 8'h0F;
        check("b2b_not", 0, int'(res[0]), 8'h33);
        @(negedge clk);
        in_valid = 1'b0;
        check("b2b_and", 0, int'(res[0]), 8'h03);
        check("b2b_ov",  0, int'(ovd[0]), 1);

        // power drop during multiply
        do_op(3'd6, 1'b0, 8'd3, 8'd4);
        on = 1'b0;
        wait_valid();
        check("drop_res", 0, int'(res[0]), 12);
        check("drop_st",  0, int'(st[0]),  0);
        op = 3'd4; use_acc = 1'b0; a = 8'd1; b = 8'd1; in_valid = 1'b1;
        repeat (4) @(negedge clk);
        check("drop_hold", 0, int'(res[0]), 12);
        check("drop_off",  0, int'(st[0]),  0);
        in_valid = 1'b0;

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end
endmodule
